// File: rtl/register_bank.sv
// register_bank: 32 x DATA_WIDTH MIPS general-purpose register file.
// One write port, two registered read ports with write-first bypass.
module register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_RESET = DATA_WIDTH'(227)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg_1,
  input  logic [4:0]            read_reg_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  logic [DATA_WIDTH-1:0] regs [32];
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd1_n;
  logic [DATA_WIDTH-1:0] rd2_n;

  // $0 is never written, so it holds its reset zero forever
  assign wr_en = reg_write && (write_reg != 5'd0);

  always_comb begin
    rd1_n = '0;
    rd2_n = '0;
    unique case (1'b1)
      (read_reg_1 == 5'd0):
        rd1_n = '0;
      (wr_en && write_reg == read_reg_1):
        rd1_n = write_data;
      default:
        rd1_n = regs[read_reg_1];
    endcase
    unique case (1'b1)
      (read_reg_2 == 5'd0):
        rd2_n = '0;
      (wr_en && write_reg == read_reg_2):
        rd2_n = write_data;
      default:
        rd2_n = regs[read_reg_2];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 29) ? SP_RESET : '0;
      end
      read_data_1 <= '0;
      read_data_2 <= '0;
    end else begin
      if (wr_en) begin
        regs[write_reg] <= write_data;
      end
      read_data_1 <= rd1_n;
      read_data_2 <= rd2_n;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed self-checking bench for register_bank.
// Each scenario task drives vectors and compares against hand values.
module tb_register_bank;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int checks = 0;
  int errors = 0;

  register_bank #(
    .DATA_WIDTH(32),
    .SP_RESET(32'd227)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_write(reg_write),
    .write_reg(write_reg),
    .write_data(write_data),
    .read_reg_1(read_reg_1),
    .read_reg_2(read_reg_2),
    .read_data_1(read_data_1),
    .read_data_2(read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reset = rst;
    reg_write = we;
    write_reg = wr;
    write_data = wd;
    read_reg_1 = r1;
    read_reg_2 = r2;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd29, 5'd5);
    tick();
    checks++;
    if (read_data_1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd1 got %h exp %h", read_data_1, 32'h0);
    end
    checks++;
    if (read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd2 got %h exp %h", read_data_2, 32'h0);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
    tick();
    checks++;
    if (read_data_1 !== 32'h0000_00E3) begin
      errors++;
      $display("FAIL reset_sp got %h exp %h", read_data_1, 32'hE3);
    end
    checks++;
    if (read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5 got %h exp %h", read_data_2, 32'h0);
    end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 5'd8, 32'h1234_5678, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
    tick();
    checks++;
    if (read_data_1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL basic_rd1 got %h exp %h", read_data_1, 32'h1234_5678);
    end
    checks++;
    if (read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL basic_rd2 got %h exp %h", read_data_2, 32'h0);
    end
  endtask

  task automatic test_zero();
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    tick();
    checks++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_nobypass got %h/%h exp 0/0",
               read_data_1, read_data_2);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    checks++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_stored got %h/%h exp 0/0",
               read_data_1, read_data_2);
    end
  endtask

  task automatic test_bypass();
    drive(1'b0, 1'b1, 5'd31, 32'h0040_0008, 5'd31, 5'd31);
    tick();
    checks++;
    if (read_data_1 !== 32'h0040_0008) begin
      errors++;
      $display("FAIL bypass_rd1 got %h exp %h", read_data_1, 32'h0040_0008);
    end
    checks++;
    if (read_data_2 !== 32'h0040_0008) begin
      errors++;
      $display("FAIL bypass_rd2 got %h exp %h", read_data_2, 32'h0040_0008);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd8);
    tick();
    checks++;
    if (read_data_1 !== 32'h0040_0008) begin
      errors++;
      $display("FAIL bypass_stored got %h exp %h", read_data_1, 32'h0040_0008);
    end
    checks++;
    if (read_data_2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bypass_other got %h exp %h", read_data_2, 32'h1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 5'd29, 32'h0000_00E0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd29, 32'h0000_00DC, 5'd29, 5'd8);
    tick();
    checks++;
    if (read_data_1 !== 32'h0000_00DC) begin
      errors++;
      $display("FAIL b2b_bypass got %h exp %h", read_data_1, 32'hDC);
    end
    checks++;
    if (read_data_2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_port2 got %h exp %h", read_data_2, 32'h1234_5678);
    end
    drive(1'b0, 1'b0, 5'd29, 32'h0000_0001, 5'd29, 5'd29);
    tick();
    checks++;
    if (read_data_1 !== 32'h0000_00DC || read_data_2 !== 32'h0000_00DC) begin
      errors++;
      $display("FAIL b2b_hold got %h/%h exp %h", read_data_1, read_data_2,
               32'hDC);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'(i * 4), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd29);
    tick();
    checks++;
    if (read_data_1 !== 32'd28 || read_data_2 !== 32'd116) begin
      errors++;
      $display("FAIL fill got %h/%h exp %h/%h", read_data_1, read_data_2,
               32'd28, 32'd116);
    end
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0005, 5'd7, 5'd3);
    tick();
    checks++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL midreset_out got %h/%h exp 0/0",
               read_data_1, read_data_2);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1;
      logic [31:0] e2;
      e1 = (i == 29) ? 32'd227 : 32'd0;
      e2 = ((31 - i) == 29) ? 32'd227 : 32'd0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      tick();
      checks++;
      if (read_data_1 !== e1 || read_data_2 !== e2) begin
        errors++;
        $display("FAIL sweep_%0d got %h/%h exp %h/%h", i,
                 read_data_1, read_data_2, e1, e2);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
